l2_mshr_pool: RTL and testbench

Parametrised miss-status holding register pool for the Spandex L2. It replaces the fixed `N_MSHR` table with a pool of configurable depth, line word count and number of lookup ports. It adds lowest-free allocation, word-mask merge on update, set-conflict detection per lookup port, and a fence-drain handshake. It sits between the L2 FSM, which allocates, updates and frees entries, and the input paths (CPU request, forward, response), which look up entries.

---
 rtl/l2_mshr_pool_pkg.sv | 45 ++++
 rtl/mshr_pool_prio_enc.sv | 28 ++
 rtl/l2_mshr_pool.sv | 228 ++++++++++++++++++++++
 tb/tb_l2_mshr_pool.sv | 372 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/l2_mshr_pool_pkg.sv
// rtl/l2_mshr_pool_pkg.sv - shared types and pool defaults for the L2 MSHR pool
//
// Contents:
//   N_MSHR_POOL*      default pool geometry (depth, key widths, words, lookup ports)
//   unstable_state_t  transient coherence state held by an in-flight miss
//   mshr_pool_entry_t one pool entry as seen on the read port
//   drain_state_t     fence-drain controller states
package l2_mshr_pool_pkg;

  localparam int N_MSHR_POOL          = 8;
  localparam int N_MSHR_POOL_TAG_W    = 20;
  localparam int N_MSHR_POOL_SET_W    = 8;
  localparam int N_MSHR_POOL_WAY_W    = 3;
  localparam int N_MSHR_POOL_WORDS    = 4;
  localparam int N_MSHR_POOL_N_LOOKUP = 2;

  typedef enum logic [2:0] {
    US_NONE = 3'd0,
    US_IV   = 3'd1,
    US_IS   = 3'd2,
    US_IO   = 3'd3,
    US_SI   = 3'd4,
    US_OI   = 3'd5,
    US_RI   = 3'd6,
    US_XV   = 3'd7
  } unstable_state_t;

  // Field widths track the pool defaults above; the pool must be built with
  // matching TAG_W/SET_W/WAY_W/WORDS.
  typedef struct packed {
    logic                         valid;
    logic [N_MSHR_POOL_TAG_W-1:0] tag;
    logic [N_MSHR_POOL_SET_W-1:0] set_idx;
    logic [N_MSHR_POOL_WAY_W-1:0] way;
    unstable_state_t              state;
    logic [N_MSHR_POOL_WORDS-1:0] word_mask;
  } mshr_pool_entry_t;

  typedef enum logic [1:0] {
    DRN_IDLE  = 2'd0,
    DRN_DRAIN = 2'd1,
    DRN_DONE  = 2'd2
  } drain_state_t;

endpackage

// File: rtl/mshr_pool_prio_enc.sv
// rtl/mshr_pool_prio_enc.sv - lowest-set-bit priority encoder
//
// Ports:
//   req   in  N  request vector
//   idx   out W  index of the lowest set bit, 0 when none is set
//   found out 1  at least one bit of req is set
module mshr_pool_prio_enc #(
  parameter  int N = 8,
  localparam int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] req,
  output logic [W-1:0] idx,
  output logic         found
);

  // Scanning from the top down lets the last hit (the lowest index) win.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx   = W'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/l2_mshr_pool.sv
// rtl/l2_mshr_pool.sv - parametrised L2 miss-status holding register pool
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   alloc_*                  allocation handshake and new-entry fields; alloc_idx = slot to be used
//   upd_*                    update of an entry's state and word mask (merge ORs, else replace)
//   free_valid, free_idx     release of an entry
//   lk_tag, lk_set           per-port lookup keys (flattened, port p at [p*W +: W])
//   lk_hit, lk_idx           per-port exact match and its lowest matching index
//   lk_set_conflict          per-port "some valid entry uses this set"
//   rd_idx, rd_entry         entry read port
//   cnt, full, empty         occupancy
//   drain_req, drain_done    fence drain request (level) and one-cycle completion pulse
//   proto_err                sticky protocol-error flag
module l2_mshr_pool
  import l2_mshr_pool_pkg::*;
#(
  parameter  int N_ENTRIES = N_MSHR_POOL,
  parameter  int TAG_W     = N_MSHR_POOL_TAG_W,
  parameter  int SET_W     = N_MSHR_POOL_SET_W,
  parameter  int WAY_W     = N_MSHR_POOL_WAY_W,
  parameter  int WORDS     = N_MSHR_POOL_WORDS,
  parameter  int N_LOOKUP  = N_MSHR_POOL_N_LOOKUP,
  localparam int IDX_W     = $clog2(N_ENTRIES)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      alloc_valid,
  output logic                      alloc_ready,
  input  logic [TAG_W-1:0]          alloc_tag,
  input  logic [SET_W-1:0]          alloc_set,
  input  logic [WAY_W-1:0]          alloc_way,
  input  unstable_state_t           alloc_state,
  input  logic [WORDS-1:0]          alloc_word_mask,
  output logic [IDX_W-1:0]          alloc_idx,
  input  logic                      upd_valid,
  input  logic [IDX_W-1:0]          upd_idx,
  input  unstable_state_t           upd_state,
  input  logic [WORDS-1:0]          upd_word_mask,
  input  logic                      upd_merge,
  input  logic                      free_valid,
  input  logic [IDX_W-1:0]          free_idx,
  input  logic [N_LOOKUP*TAG_W-1:0] lk_tag,
  input  logic [N_LOOKUP*SET_W-1:0] lk_set,
  output logic [N_LOOKUP-1:0]       lk_hit,
  output logic [N_LOOKUP*IDX_W-1:0] lk_idx,
  output logic [N_LOOKUP-1:0]       lk_set_conflict,
  input  logic [IDX_W-1:0]          rd_idx,
  output mshr_pool_entry_t          rd_entry,
  output logic [IDX_W:0]            cnt,
  output logic                      full,
  output logic                      empty,
  input  logic                      drain_req,
  output logic                      drain_done,
  output logic                      proto_err
);

  localparam logic [IDX_W:0] CNT_ONE  = (IDX_W + 1)'(1);
  localparam logic [IDX_W:0] CNT_FULL = (IDX_W + 1)'(N_ENTRIES);

  mshr_pool_entry_t entry_q [N_ENTRIES];
  mshr_pool_entry_t entry_d [N_ENTRIES];
  logic [IDX_W:0]   cnt_q, cnt_d;
  drain_state_t     fsm_q, fsm_d;
  logic             armed_q, armed_d;
  logic             proto_err_q, proto_err_d;

  logic [N_ENTRIES-1:0] free_vec;
  logic [N_ENTRIES-1:0] dup_vec;
  logic                 alloc_found;
  logic                 alloc_fire;
  logic                 alloc_dup;
  logic                 alloc_wr;
  logic                 free_ok;
  logic                 upd_shadowed;

  logic [N_ENTRIES-1:0] lk_match     [N_LOOKUP];
  logic [N_ENTRIES-1:0] lk_set_match [N_LOOKUP];

  // ---------------- allocation ----------------
  always_comb begin
    free_vec = '0;
    dup_vec  = '0;
    for (int i = 0; i < N_ENTRIES; i++) begin
      free_vec[i] = !entry_q[i].valid;
      dup_vec[i]  = entry_q[i].valid && (entry_q[i].tag == alloc_tag) &&
                    (entry_q[i].set_idx == alloc_set);
    end
  end

  mshr_pool_prio_enc #(.N(N_ENTRIES)) u_alloc_enc (
    .req   (free_vec),
    .idx   (alloc_idx),
    .found (alloc_found)
  );

  assign full        = (cnt_q == CNT_FULL);
  assign empty       = (cnt_q == '0);
  assign cnt         = cnt_q;
  assign alloc_ready = !full && (fsm_q == DRN_IDLE);
  assign alloc_fire  = alloc_valid && alloc_ready;
  assign alloc_dup   = |dup_vec;
  // A duplicate key is consumed (handshake completes) but never written.
  assign alloc_wr    = alloc_fire && !alloc_dup && alloc_found;
  assign free_ok     = free_valid && entry_q[free_idx].valid;
  // A free to the same slot overrides the update without flagging it.
  assign upd_shadowed = free_valid && (free_idx == upd_idx);

  // ---------------- entry table next state ----------------
  always_comb begin
    entry_d     = entry_q;
    proto_err_d = proto_err_q;

    if (alloc_fire && alloc_dup) begin
      proto_err_d = 1'b1;
    end
    if (alloc_wr) begin
      entry_d[alloc_idx].valid     = 1'b1;
      entry_d[alloc_idx].tag       = alloc_tag;
      entry_d[alloc_idx].set_idx   = alloc_set;
      entry_d[alloc_idx].way       = alloc_way;
      entry_d[alloc_idx].state     = alloc_state;
      entry_d[alloc_idx].word_mask = alloc_word_mask;
    end

    // The slot being allocated is still invalid in entry_q, so an update
    // aimed at it lands in the error branch below.
    if (upd_valid && !upd_shadowed) begin
      if (entry_q[upd_idx].valid) begin
        entry_d[upd_idx].state     = upd_state;
        entry_d[upd_idx].word_mask = upd_merge ? (entry_q[upd_idx].word_mask | upd_word_mask)
                                               : upd_word_mask;
      end else begin
        proto_err_d = 1'b1;
      end
    end

    if (free_valid) begin
      if (entry_q[free_idx].valid) begin
        entry_d[free_idx].valid = 1'b0;
      end else begin
        proto_err_d = 1'b1;
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (alloc_wr && !free_ok) begin
      cnt_d = cnt_q + CNT_ONE;
    end else if (!alloc_wr && free_ok) begin
      cnt_d = cnt_q - CNT_ONE;
    end
  end

  // ---------------- drain controller ----------------
  always_comb begin
    fsm_d   = fsm_q;
    armed_d = armed_q || !drain_req;
    case (fsm_q)
      DRN_IDLE: begin
        if (drain_req && armed_q) begin
          fsm_d   = DRN_DRAIN;
          armed_d = 1'b0;
        end
      end
      DRN_DRAIN: begin
        if (cnt_q == '0) begin
          fsm_d = DRN_DONE;
        end
      end
      DRN_DONE: begin
        fsm_d = DRN_IDLE;
      end
      default: begin
        fsm_d = DRN_IDLE;
      end
    endcase
  end

  assign drain_done = (fsm_q == DRN_DONE);
  assign proto_err  = proto_err_q;

  // ---------------- lookup ports (registered entries only) ----------------
  always_comb begin
    for (int p = 0; p < N_LOOKUP; p++) begin
      lk_match[p]     = '0;
      lk_set_match[p] = '0;
      for (int i = 0; i < N_ENTRIES; i++) begin
        lk_set_match[p][i] = entry_q[i].valid &&
                             (entry_q[i].set_idx == lk_set[p*SET_W +: SET_W]);
        lk_match[p][i]     = lk_set_match[p][i] &&
                             (entry_q[i].tag == lk_tag[p*TAG_W +: TAG_W]);
      end
    end
  end

  for (genvar gp = 0; gp < N_LOOKUP; gp++) begin : g_lk
    mshr_pool_prio_enc #(.N(N_ENTRIES)) u_lk_enc (
      .req   (lk_match[gp]),
      .idx   (lk_idx[gp*IDX_W +: IDX_W]),
      .found (lk_hit[gp])
    );
    assign lk_set_conflict[gp] = |lk_set_match[gp];
  end

  assign rd_entry = entry_q[rd_idx];

  // ---------------- state registers ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_ENTRIES; i++) begin
        entry_q[i] <= '0;
      end
      cnt_q       <= '0;
      fsm_q       <= DRN_IDLE;
      armed_q     <= 1'b1;
      proto_err_q <= 1'b0;
    end else begin
      entry_q     <= entry_d;
      cnt_q       <= cnt_d;
      fsm_q       <= fsm_d;
      armed_q     <= armed_d;
      proto_err_q <= proto_err_d;
    end
  end

endmodule

// File: tb/tb_l2_mshr_pool.sv
// tb/tb_l2_mshr_pool.sv - self-checking bench for l2_mshr_pool
module tb_l2_mshr_pool;
  import l2_mshr_pool_pkg::*;

  localparam int N  = 8;
  localparam int IW = 3;
  localparam int TW = 20;
  localparam int SW = 8;
  localparam int WW = 3;
  localparam int WD = 4;
  localparam int NL = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst;
  logic                 alloc_valid;
  logic                 alloc_ready;
  logic [TW-1:0]        alloc_tag;
  logic [SW-1:0]        alloc_set;
  logic [WW-1:0]        alloc_way;
  unstable_state_t      alloc_state;
  logic [WD-1:0]        alloc_word_mask;
  logic [IW-1:0]        alloc_idx;
  logic                 upd_valid;
  logic [IW-1:0]        upd_idx;
  unstable_state_t      upd_state;
  logic [WD-1:0]        upd_word_mask;
  logic                 upd_merge;
  logic                 free_valid;
  logic [IW-1:0]        free_idx;
  logic [NL*TW-1:0]     lk_tag;
  logic [NL*SW-1:0]     lk_set;
  logic [NL-1:0]        lk_hit;
  logic [NL*IW-1:0]     lk_idx;
  logic [NL-1:0]        lk_set_conflict;
  logic [IW-1:0]        rd_idx;
  mshr_pool_entry_t     rd_entry;
  logic [IW:0]          cnt;
  logic                 full;
  logic                 empty;
  logic                 drain_req;
  logic                 drain_done;
  logic                 proto_err;

  l2_mshr_pool dut (
    .clk(clk), .rst(rst),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
    .alloc_set(alloc_set), .alloc_way(alloc_way), .alloc_state(alloc_state),
    .alloc_word_mask(alloc_word_mask), .alloc_idx(alloc_idx),
    .upd_valid(upd_valid), .upd_idx(upd_idx), .upd_state(upd_state),
    .upd_word_mask(upd_word_mask), .upd_merge(upd_merge),
    .free_valid(free_valid), .free_idx(free_idx),
    .lk_tag(lk_tag), .lk_set(lk_set), .lk_hit(lk_hit), .lk_idx(lk_idx),
    .lk_set_conflict(lk_set_conflict),
    .rd_idx(rd_idx), .rd_entry(rd_entry),
    .cnt(cnt), .full(full), .empty(empty),
    .drain_req(drain_req), .drain_done(drain_done), .proto_err(proto_err)
  );

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a plain table of entries plus drain mode
  // (0 idle, 1 draining, 2 done pulse).
  bit            m_valid [N];
  logic [TW-1:0] m_tag   [N];
  logic [SW-1:0] m_set   [N];
  logic [WW-1:0] m_way   [N];
  logic [2:0]    m_state [N];
  logic [WD-1:0] m_mask  [N];
  int            m_mode;
  bit            m_armed;
  bit            m_err;

  function automatic int count_valid();
    int c = 0;
    for (int i = 0; i < N; i++) c += m_valid[i] ? 1 : 0;
    return c;
  endfunction

  function automatic int lowest_free();
    for (int i = 0; i < N; i++) if (!m_valid[i]) return i;
    return -1;
  endfunction

  task automatic clr();
    alloc_valid = 1'b0;
    upd_valid   = 1'b0;
    free_valid  = 1'b0;
  endtask

  task automatic check_all();
    int c, lf;
    c  = count_valid();
    lf = lowest_free();
    chk("cnt", cnt, c);
    chk("full", full, c == N);
    chk("empty", empty, c == 0);
    chk("alloc_ready", alloc_ready, (c != N) && (m_mode == 0));
    chk("alloc_idx", alloc_idx, (lf < 0) ? 0 : lf);
    chk("drain_done", drain_done, m_mode == 2);
    chk("proto_err", proto_err, m_err);
    for (int p = 0; p < NL; p++) begin
      logic [TW-1:0] kt;
      logic [SW-1:0] ks;
      bit eh, ec;
      int ei;
      kt = lk_tag[p*TW +: TW];
      ks = lk_set[p*SW +: SW];
      eh = 0; ec = 0; ei = 0;
      for (int i = 0; i < N; i++) begin
        if (m_valid[i] && m_set[i] == ks) begin
          ec = 1;
          if (!eh && m_tag[i] == kt) begin
            eh = 1;
            ei = i;
          end
        end
      end
      chk($sformatf("lk_hit%0d", p), lk_hit[p], eh);
      chk($sformatf("lk_idx%0d", p), lk_idx[p*IW +: IW], ei);
      chk($sformatf("lk_conf%0d", p), lk_set_conflict[p], ec);
    end
    chk("rd_valid", rd_entry.valid, m_valid[rd_idx]);
    chk("rd_tag", rd_entry.tag, m_tag[rd_idx]);
    chk("rd_set", rd_entry.set_idx, m_set[rd_idx]);
    chk("rd_way", rd_entry.way, m_way[rd_idx]);
    chk("rd_state", rd_entry.state, m_state[rd_idx]);
    chk("rd_mask", rd_entry.word_mask, m_mask[rd_idx]);
  endtask

  // Predict the effect of the current inputs, clock once, then compare.
  task automatic cycle();
    bit            nv [N];
    logic [TW-1:0] nt [N];
    logic [SW-1:0] ns [N];
    logic [WW-1:0] nw [N];
    logic [2:0]    nst[N];
    logic [WD-1:0] nm [N];
    int  n_mode, c, aidx;
    bit  n_armed, n_err, dup;
    nv = m_valid; nt = m_tag; ns = m_set; nw = m_way; nst = m_state; nm = m_mask;
    n_mode = m_mode; n_armed = m_armed; n_err = m_err;
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        nv[i] = 0; nt[i] = '0; ns[i] = '0; nw[i] = '0; nst[i] = '0; nm[i] = '0;
      end
      n_mode = 0; n_armed = 1; n_err = 0;
    end else begin
      c    = count_valid();
      aidx = lowest_free();
      dup  = 0;
      for (int i = 0; i < N; i++)
        if (m_valid[i] && m_tag[i] == alloc_tag && m_set[i] == alloc_set) dup = 1;
      if (alloc_valid && c != N && m_mode == 0) begin
        if (dup) n_err = 1;
        else begin
          nv[aidx] = 1; nt[aidx] = alloc_tag; ns[aidx] = alloc_set;
          nw[aidx] = alloc_way; nst[aidx] = alloc_state; nm[aidx] = alloc_word_mask;
        end
      end
      if (upd_valid && !(free_valid && free_idx == upd_idx)) begin
        if (m_valid[upd_idx]) begin
          nst[upd_idx] = upd_state;
          nm[upd_idx]  = upd_merge ? (m_mask[upd_idx] | upd_word_mask) : upd_word_mask;
        end else n_err = 1;
      end
      if (free_valid) begin
        if (m_valid[free_idx]) nv[free_idx] = 0;
        else n_err = 1;
      end
      n_armed = m_armed || !drain_req;
      if (m_mode == 0 && drain_req && m_armed) begin
        n_mode = 1; n_armed = 0;
      end else if (m_mode == 1 && c == 0) n_mode = 2;
      else if (m_mode == 2) n_mode = 0;
    end
    @(posedge clk);
    #1;
    m_valid = nv; m_tag = nt; m_set = ns; m_way = nw; m_state = nst; m_mask = nm;
    m_mode = n_mode; m_armed = n_armed; m_err = n_err;
    check_all();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clr();
    drain_req = 1'b0;
    cycle();
    cycle();
    rst = 1'b0;
  endtask

  task automatic do_alloc(input int t, input int s, input logic [WD-1:0] mask);
    alloc_valid     = 1'b1;
    alloc_tag       = TW'(t);
    alloc_set       = SW'(s);
    alloc_way       = WW'(s);
    alloc_state     = US_IS;
    alloc_word_mask = mask;
    cycle();
    clr();
  endtask

  task automatic set_key(input int p, input int t, input int s);
    lk_tag[p*TW +: TW] = TW'(t);
    lk_set[p*SW +: SW] = SW'(s);
  endtask

  function automatic int pick_idx(input bit want_valid);
    int k = 0;
    for (int t = 0; t < 8; t++) begin
      k = $urandom_range(0, N - 1);
      if (m_valid[k] == want_valid) return k;
    end
    return k;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish, got=running exp=done");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses, first;
    rst = 1'b1; drain_req = 1'b0; clr();
    alloc_tag = '0; alloc_set = '0; alloc_way = '0; alloc_state = US_NONE; alloc_word_mask = '0;
    upd_idx = '0; upd_state = US_NONE; upd_word_mask = '0; upd_merge = 1'b0;
    free_idx = '0; lk_tag = '0; lk_set = '0; rd_idx = '0;

    // Reset state and fill the pool with sets 0..7.
    do_reset();
    chk("rst_cnt", cnt, 0);
    chk("rst_empty", empty, 1);
    chk("rst_ready", alloc_ready, 1);
    chk("rst_alloc_idx", alloc_idx, 0);
    chk("rst_perr", proto_err, 0);
    for (int i = 0; i < N; i++) begin
      chk("fill_idx", alloc_idx, i);
      do_alloc(100 + i, i, 4'b0001);
    end
    chk("fill_cnt", cnt, 8);
    chk("fill_full", full, 1);
    chk("fill_ready", alloc_ready, 0);

    // Free idx 3 with an alloc held: the alloc waits for the slot, then lands in it.
    set_key(0, 200, 3);
    rd_idx = 3;
    free_valid = 1'b1; free_idx = 3;
    alloc_valid = 1'b1; alloc_tag = 200; alloc_set = 3; alloc_way = 1;
    alloc_state = US_IV; alloc_word_mask = 4'b1111;
    cycle();
    free_valid = 1'b0;
    chk("full_free_cnt", cnt, 7);
    cycle();
    clr();
    chk("refill_cnt", cnt, 8);
    chk("refill_hit", lk_hit[0], 1);
    chk("refill_idx", lk_idx[IW-1:0], 3);
    chk("refill_tag", rd_entry.tag, 200);

    // Alloc and free together on a non-full pool: count unchanged.
    free_valid = 1'b1; free_idx = 5; cycle(); clr();
    chk("pre_af_cnt", cnt, 7);
    alloc_valid = 1'b1; alloc_tag = 300; alloc_set = 9; free_valid = 1'b1; free_idx = 0;
    cycle(); clr();
    chk("af_cnt", cnt, 7);

    // Word-mask merge then replace.
    do_reset();
    rd_idx = 0;
    do_alloc(7, 1, 4'b0011);
    upd_valid = 1'b1; upd_idx = 0; upd_state = US_SI; upd_word_mask = 4'b0100; upd_merge = 1'b1;
    cycle(); clr();
    chk("merge_mask", rd_entry.word_mask, 4'b0111);
    upd_valid = 1'b1; upd_word_mask = 4'b1000; upd_merge = 1'b0;
    cycle(); clr();
    chk("replace_mask", rd_entry.word_mask, 4'b1000);

    // Set conflict on port 1.
    do_reset();
    do_alloc(1, 5, 4'b0001);
    do_alloc(2, 5, 4'b0010);
    set_key(1, 9, 5);
    cycle();
    chk("conf_conflict", lk_set_conflict[1], 1);
    chk("conf_nohit", lk_hit[1], 0);
    set_key(1, 2, 5);
    cycle();
    chk("conf_hit", lk_hit[1], 1);
    chk("conf_idx", lk_idx[IW +: IW], 1);

    // Drain with three live entries.
    do_reset();
    for (int i = 0; i < 3; i++) do_alloc(40 + i, i, 4'b0001);
    drain_req = 1'b1;
    cycle();
    chk("drain_ready", alloc_ready, 0);
    for (int i = 0; i < 3; i++) begin
      free_valid = 1'b1; free_idx = IW'(i); cycle(); clr();
    end
    chk("drain_cnt0", cnt, 0);
    chk("drain_not_yet", drain_done, 0);
    pulses = 0; first = -1;
    for (int k = 0; k < 10; k++) begin
      cycle();
      if (drain_done) begin
        pulses++;
        if (first < 0) first = k;
      end
    end
    chk("drain_pulses", pulses, 1);
    chk("drain_when", first, 0);
    chk("drain_ready_back", alloc_ready, 1);
    drain_req = 1'b0;
    cycle();

    // Protocol errors are sticky until reset.
    do_reset();
    do_alloc(5, 5, 4'b0001);
    free_valid = 1'b1; free_idx = 4; cycle(); clr();
    chk("err_free_perr", proto_err, 1);
    chk("err_free_cnt", cnt, 1);
    do_alloc(5, 5, 4'b0010);
    chk("err_dup_cnt", cnt, 1);
    for (int k = 0; k < 5; k++) cycle();
    chk("err_sticky", proto_err, 1);
    do_reset();
    chk("err_cleared", proto_err, 0);

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 149) == 0);
      alloc_valid     = $urandom_range(0, 1);
      alloc_tag       = TW'($urandom_range(0, 7));
      alloc_set       = SW'($urandom_range(0, 3));
      alloc_way       = WW'($urandom);
      alloc_state     = unstable_state_t'($urandom_range(0, 7));
      alloc_word_mask = WD'($urandom);
      upd_valid       = ($urandom_range(0, 9) < 3);
      upd_idx         = IW'(pick_idx($urandom_range(0, 9) < 8));
      upd_state       = unstable_state_t'($urandom_range(0, 7));
      upd_word_mask   = WD'($urandom);
      upd_merge       = $urandom_range(0, 1);
      free_valid      = ($urandom_range(0, 9) < 3);
      free_idx        = IW'(pick_idx($urandom_range(0, 9) < 8));
      if ($urandom_range(0, 19) == 0) drain_req = !drain_req;
      rd_idx = IW'($urandom_range(0, N - 1));
      for (int p = 0; p < NL; p++) begin
        int k;
        k = $urandom_range(0, N - 1);
        if ($urandom_range(0, 1) == 1) set_key(p, int'(m_tag[k]), int'(m_set[k]));
        else set_key(p, $urandom_range(0, 7), $urandom_range(0, 3));
      end
      cycle();
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
